// File: rtl/arb_req_frontend.sv
// arb_req_frontend: per-channel saturating job queues driving a 3-way round-robin arbiter.
// Optional starvation monitor is compiled in with `define STARVE_CHECK_EN.
module arb_req_frontend #(
    parameter int CNT_W    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_a,
    input  logic             job_b,
    input  logic             job_c,
    input  logic             grant_a,
    input  logic             grant_b,
    input  logic             grant_c,
    output logic             req_a,
    output logic             req_b,
    output logic             req_c,
    output logic [CNT_W-1:0] pend_a,
    output logic [CNT_W-1:0] pend_b,
    output logic [CNT_W-1:0] pend_c,
    output logic             done,
    output logic [1:0]       done_id,
    output logic             err_ovf,
    output logic             err_spur,
    output logic             err_multi,
    output logic [2:0]       starve
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [CNT_W-1:0] pend [3];
    logic [2:0]       job;
    logic [2:0]       grant;
    logic [2:0]       req;
    logic [2:0]       valid;
    logic             multi;

    assign job   = {job_c, job_b, job_a};
    assign grant = {grant_c, grant_b, grant_a};

    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            req[i] = (pend[i] != '0);
        end
    end

    // A grant only counts when it is the sole grant and the channel is requesting.
    assign multi = (grant[0] & grant[1]) | (grant[0] & grant[2]) | (grant[1] & grant[2]);
    assign valid = grant & req & {3{~multi}};

    assign req_a  = req[0];
    assign req_b  = req[1];
    assign req_c  = req[2];
    assign pend_a = pend[0];
    assign pend_b = pend[1];
    assign pend_c = pend[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                pend[i] <= '0;
            end
            done      <= 1'b0;
            done_id   <= '0;
            err_ovf   <= 1'b0;
            err_spur  <= 1'b0;
            err_multi <= 1'b0;
        end else begin
            done <= |valid;
            if (valid[0])      done_id <= 2'd0;
            else if (valid[1]) done_id <= 2'd1;
            else if (valid[2]) done_id <= 2'd2;

            for (int unsigned i = 0; i < 3; i++) begin
                if (job[i] && !valid[i]) begin
                    if (pend[i] == PEND_MAX) err_ovf <= 1'b1;
                    else                     pend[i] <= pend[i] + CNT_W'(1);
                end else if (!job[i] && valid[i]) begin
                    pend[i] <= pend[i] - CNT_W'(1);
                end
            end

            if (|(grant & ~req)) err_spur  <= 1'b1;
            if (multi)           err_multi <= 1'b1;
        end
    end

`ifdef STARVE_CHECK_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt [3];
    logic [2:0]        starve_q;

    // Flag is raised on the same edge the saturating wait counter reaches its limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                wait_cnt[i] <= '0;
            end
            starve_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (!req[i] || valid[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != WAIT_MAX) begin
                    wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
                    if (wait_cnt[i] + WAIT_W'(1) == WAIT_MAX) starve_q[i] <= 1'b1;
                end
            end
        end
    end

    assign starve = starve_q;
`else
    assign starve = 3'b000;
`endif

endmodule

// File: tb/tb_arb_req_frontend.sv
// Self-checking bench for arb_req_frontend: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the queue/grant rules.
module tb_arb_req_frontend;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 3;
    localparam int PMAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic job_a = 1'b0, job_b = 1'b0, job_c = 1'b0;
    logic grant_a = 1'b0, grant_b = 1'b0, grant_c = 1'b0;
    logic req_a, req_b, req_c;
    logic [CNT_W-1:0] pend_a, pend_b, pend_c;
    logic done;
    logic [1:0] done_id;
    logic err_ovf, err_spur, err_multi;
    logic [2:0] starve;

    arb_req_frontend #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .job_a(job_a), .job_b(job_b), .job_c(job_c),
        .grant_a(grant_a), .grant_b(grant_b), .grant_c(grant_c),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .pend_a(pend_a), .pend_b(pend_b), .pend_c(pend_c),
        .done(done), .done_id(done_id),
        .err_ovf(err_ovf), .err_spur(err_spur), .err_multi(err_multi),
        .starve(starve)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int       m_pend [3];
    int       m_wait [3];
    bit       m_done;
    int       m_done_id;
    bit       m_ovf, m_spur, m_multi;
    bit [2:0] m_starve;

    logic [23:0] obs;
    assign obs = {req_c, req_b, req_a, pend_c, pend_b, pend_a, done, done_id,
                  err_ovf, err_spur, err_multi, starve};

    function automatic logic [23:0] exp_vec();
        logic [2:0] r;
        for (int ch = 0; ch < 3; ch++) r[ch] = (m_pend[ch] > 0);
        return {r, 4'(m_pend[2]), 4'(m_pend[1]), 4'(m_pend[0]), m_done, 2'(m_done_id),
                m_ovf, m_spur, m_multi, m_starve};
    endfunction

    // Applies one clock cycle of the job/grant rules to the model.
    task automatic model_step(input bit [2:0] j, input bit [2:0] g, input bit r);
        int ng, old, net;
        bit ok;
        if (r) begin
            for (int ch = 0; ch < 3; ch++) begin m_pend[ch] = 0; m_wait[ch] = 0; end
            m_done = 0; m_done_id = 0; m_ovf = 0; m_spur = 0; m_multi = 0; m_starve = '0;
            return;
        end
        ng = int'(g[0]) + int'(g[1]) + int'(g[2]);
        if (ng > 1) m_multi = 1;
        m_done = 0;
        for (int ch = 0; ch < 3; ch++) begin
            old = m_pend[ch];
            if (g[ch] && old == 0) m_spur = 1;
            ok = (ng == 1) && g[ch] && (old > 0);
            if (ok) begin m_done = 1; m_done_id = ch; end
            net = int'(j[ch]) - int'(ok);
            if (net > 0) begin
                if (old == PMAX) m_ovf = 1;
                else m_pend[ch] = old + 1;
            end else if (net < 0) begin
                m_pend[ch] = old - 1;
            end
`ifdef STARVE_CHECK_EN
            if (old > 0 && !ok) m_wait[ch] = (m_wait[ch] < MAX_WAIT) ? m_wait[ch] + 1 : MAX_WAIT;
            else m_wait[ch] = 0;
            if (m_wait[ch] == MAX_WAIT) m_starve[ch] = 1;
`endif
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, sample #1 after the edge.
    task automatic cycle(input bit [2:0] j, input bit [2:0] g, input bit r);
        {job_c, job_b, job_a}       = j;
        {grant_c, grant_b, grant_a} = g;
        rst = r;
        @(posedge clk);
        model_step(j, g, r);
        #1;
        {job_c, job_b, job_a}       = '0;
        {grant_c, grant_b, grant_a} = '0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1);
        checks++;
        if (obs !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, 24'h0);
        end
    endtask

    task automatic test_single_job();
        cycle(3'b000, 3'b000, 1'b1);
        cycle(3'b001, 3'b000, 1'b0);
        checks++;
        if (req_a !== 1'b1 || pend_a !== 4'd1) begin
            errors++;
            $display("FAIL single_req: got req_a=%b pend_a=%0d expected 1/1", req_a, pend_a);
        end
        cycle(3'b000, 3'b001, 1'b0);
        checks++;
        if ({req_a, pend_a, done, done_id} !== {1'b0, 4'd0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL single_done: got req_a=%b pend_a=%0d done=%b id=%0d expected 0/0/1/0",
                     req_a, pend_a, done, done_id);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL single_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        bit [1:0] want [3] = '{2'd0, 2'd1, 2'd2};
        cycle(3'b000, 3'b000, 1'b1);
        cycle(3'b111, 3'b000, 1'b0);
        for (int ch = 0; ch < 3; ch++) begin
            cycle(3'b000, 3'(1 << ch), 1'b0);
            checks++;
            if (done !== 1'b1 || done_id !== want[ch]) begin
                errors++;
                $display("FAIL b2b_done%0d: got done=%b id=%0d expected 1/%0d", ch, done, done_id, want[ch]);
            end
        end
        checks++;
        if ({pend_c, pend_b, pend_a, err_ovf, err_spur, err_multi} !== 15'h0) begin
            errors++;
            $display("FAIL b2b_drain: got pend=%0d/%0d/%0d errs=%b%b%b expected all 0",
                     pend_a, pend_b, pend_c, err_ovf, err_spur, err_multi);
        end
        cycle(3'b000, 3'b000, 1'b0);
        checks++;
        if (done !== 1'b0 || done_id !== 2'd2) begin
            errors++;
            $display("FAIL b2b_hold_id: got done=%b id=%0d expected 0/2", done, done_id);
        end
    endtask

    task automatic test_overflow();
        cycle(3'b000, 3'b000, 1'b1);
        for (int i = 0; i < 15; i++) cycle(3'b010, 3'b000, 1'b0);
        checks++;
        if (pend_b !== 4'd15 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_at_max: got pend_b=%0d err_ovf=%b expected 15/0", pend_b, err_ovf);
        end
        cycle(3'b010, 3'b000, 1'b0);
        checks++;
        if (pend_b !== 4'd15 || err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_16th: got pend_b=%0d err_ovf=%b expected 15/1", pend_b, err_ovf);
        end
        cycle(3'b010, 3'b010, 1'b0);
        checks++;
        if (pend_b !== 4'd15 || done !== 1'b1 || done_id !== 2'd1) begin
            errors++;
            $display("FAIL ovf_inc_dec: got pend_b=%0d done=%b id=%0d expected 15/1/1", pend_b, done, done_id);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL ovf_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_spur_multi();
        cycle(3'b000, 3'b000, 1'b1);
        cycle(3'b000, 3'b100, 1'b0);
        checks++;
        if (err_spur !== 1'b1 || done !== 1'b0 || err_multi !== 1'b0) begin
            errors++;
            $display("FAIL spur: got err_spur=%b done=%b err_multi=%b expected 1/0/0", err_spur, done, err_multi);
        end
        cycle(3'b000, 3'b000, 1'b1);
        cycle(3'b011, 3'b000, 1'b0);
        cycle(3'b000, 3'b011, 1'b0);
        checks++;
        if ({err_multi, err_spur, done, pend_a, pend_b} !== {1'b1, 1'b0, 1'b0, 4'd1, 4'd1}) begin
            errors++;
            $display("FAIL multi: got multi=%b spur=%b done=%b pend_a=%0d pend_b=%0d expected 1/0/0/1/1",
                     err_multi, err_spur, done, pend_a, pend_b);
        end
    endtask

    task automatic test_starve();
        logic [2:0] want;
`ifdef STARVE_CHECK_EN
        want = 3'b001;
`else
        want = 3'b000;
`endif
        cycle(3'b000, 3'b000, 1'b1);
        cycle(3'b001, 3'b000, 1'b0);
        cycle(3'b000, 3'b000, 1'b0);
        cycle(3'b000, 3'b000, 1'b0);
        checks++;
        if (starve !== 3'b000) begin
            errors++;
            $display("FAIL starve_early: got %b expected 000", starve);
        end
        cycle(3'b000, 3'b000, 1'b0);
        checks++;
        if (starve !== want) begin
            errors++;
            $display("FAIL starve_third: got %b expected %b", starve, want);
        end
    endtask

    task automatic test_reset_mid();
        cycle(3'b000, 3'b000, 1'b1);
        for (int i = 0; i < 5; i++) cycle(3'b001, 3'b000, 1'b0);
        cycle(3'b000, 3'b001, 1'b0);
        cycle(3'b000, 3'b001, 1'b0);
        cycle(3'b000, 3'b100, 1'b0);
        for (int i = 0; i < 3; i++) cycle(3'b000, 3'b000, 1'b0);
        checks++;
        if (pend_a !== 4'd3 || err_spur !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got pend_a=%0d err_spur=%b expected 3/1", pend_a, err_spur);
        end
        cycle(3'b000, 3'b001, 1'b1);
        checks++;
        if (obs !== 24'h0) begin
            errors++;
            $display("FAIL midrst_clear: got %h expected %h", obs, 24'h0);
        end
    endtask

    task automatic test_random();
        bit [2:0] j, g;
        bit       r;
        int       pick, start, ch;
        cycle(3'b000, 3'b000, 1'b1);
        for (int n = 0; n < 400; n++) begin
            j = '0;
            for (int k = 0; k < 3; k++) j[k] = ($urandom_range(0, 99) < 40);
            g = '0;
            pick = $urandom_range(0, 99);
            if (pick < 55) begin
                start = $urandom_range(0, 2);
                for (int k = 0; k < 3; k++) begin
                    ch = (start + k) % 3;
                    if (m_pend[ch] > 0 && g == '0) g[ch] = 1'b1;
                end
            end else if (pick < 62) begin
                g = 3'(1 << $urandom_range(0, 2));
            end else if (pick < 66) begin
                g = 3'b111 & ~3'(1 << $urandom_range(0, 2));
            end
            r = ($urandom_range(0, 99) < 3);
            cycle(j, g, r);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", n, obs, exp_vec());
            end
        end
    endtask

    initial begin
        for (int ch = 0; ch < 3; ch++) begin m_pend[ch] = 0; m_wait[ch] = 0; end
        m_done = 0; m_done_id = 0; m_ovf = 0; m_spur = 0; m_multi = 0; m_starve = '0;
        test_reset();
        test_single_job();
        test_back_to_back();
        test_overflow();
        test_spur_multi();
        test_starve();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
